// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: funct3 codes,
// FSM state encoding and access-size decode.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5
  } lsu_state_e;

  // Access size in bytes; funct3[2] only selects zero-extension for loads.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    if (we) begin
      funct3_legal = (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
    end else begin
      funct3_legal = (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
                     (funct3 == LBU) || (funct3 == LHU);
    end
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables for both beats, store-data lane
// shift, and load-data extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [63:0] rbuf,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic        split,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata
);

  logic [2:0]  nbytes;
  logic [7:0]  base_mask;
  logic [7:0]  mask8;
  logic [63:0] wide;
  logic [31:0] shifted;

  assign nbytes = size_bytes(funct3);

  always_comb begin
    case (nbytes)
      3'd1:    base_mask = 8'h01;
      3'd2:    base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
  end

  // Lanes 7:4 of the mask belong to the next word, so any bit there means two beats.
  assign mask8  = base_mask << off;
  assign be0    = mask8[3:0];
  assign be1    = mask8[7:4];
  assign split  = |mask8[7:4];

  assign wide   = {32'd0, wdata} << {off, 3'b000};
  assign wdata0 = wide[31:0];
  assign wdata1 = wide[63:32];

  assign shifted = 32'(rbuf >> {off, 3'b000});

  always_comb begin
    case (funct3)
      LB:      rdata = {{24{shifted[7]}}, shifted[7:0]};
      LH:      rdata = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     rdata = {24'd0, shifted[7:0]};
      LHU:     rdata = {16'd0, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: captures one MEM-stage access, issues one or two
// word-aligned memory beats, assembles load data and reports completion.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_vld,
  input  logic        i_mem_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_fault,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvld,
  input  logic [31:0] i_dmem_rdata
);

  lsu_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic [2:0]       funct3_reg;
  logic             we_reg;
  logic [31:0]      rbuf_lo_reg;
  logic [31:0]      rbuf_hi_reg;

  logic [63:0] rbuf_cur;
  logic [3:0]  be0;
  logic [3:0]  be1;
  logic        split;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [31:0] load_data;
  logic [31:0] word_addr;
  logic        timeout_hit;

  // Merge the word arriving this cycle so the result can be registered on the same edge.
  assign rbuf_cur = (state_reg == WAIT1) ? {i_dmem_rdata, rbuf_lo_reg}
                                         : {rbuf_hi_reg, i_dmem_rdata};

  lsu_align u_align (
    .funct3 (funct3_reg),
    .off    (addr_reg[1:0]),
    .wdata  (wdata_reg),
    .rbuf   (rbuf_cur),
    .be0    (be0),
    .be1    (be1),
    .split  (split),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .rdata  (load_data)
  );

  assign word_addr   = {addr_reg[31:2], 2'b00};
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      funct3_reg  <= '0;
      we_reg      <= 1'b0;
      rbuf_lo_reg <= '0;
      rbuf_hi_reg <= '0;
      o_done      <= 1'b0;
      o_fault     <= 1'b0;
      o_rdata     <= '0;
    end else begin
      o_done  <= 1'b0;
      o_fault <= 1'b0;
      cnt_reg <= cnt_reg + CNT_W'(1);
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (i_mem_vld) begin
            addr_reg   <= i_addr;
            wdata_reg  <= i_wdata;
            funct3_reg <= i_funct3;
            we_reg     <= i_mem_we;
            if (!funct3_legal(i_mem_we, i_funct3)) begin
              state_reg <= DONE;
              o_done    <= 1'b1;
              o_fault   <= 1'b1;
            end else begin
              state_reg <= REQ0;
            end
          end
        end
        REQ0: begin
          if (i_dmem_gnt) begin
            cnt_reg <= '0;
            if (!we_reg) begin
              state_reg <= WAIT0;
            end else if (split) begin
              state_reg <= REQ1;
            end else begin
              state_reg <= DONE;
              o_done    <= 1'b1;
            end
          end else if (timeout_hit) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
            o_done    <= 1'b1;
            o_fault   <= 1'b1;
          end
        end
        WAIT0: begin
          if (i_dmem_rvld) begin
            cnt_reg     <= '0;
            rbuf_lo_reg <= i_dmem_rdata;
            if (split) begin
              state_reg <= REQ1;
            end else begin
              state_reg <= DONE;
              o_done    <= 1'b1;
              o_rdata   <= load_data;
            end
          end else if (timeout_hit) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
            o_done    <= 1'b1;
            o_fault   <= 1'b1;
          end
        end
        REQ1: begin
          if (i_dmem_gnt) begin
            cnt_reg <= '0;
            if (!we_reg) begin
              state_reg <= WAIT1;
            end else begin
              state_reg <= DONE;
              o_done    <= 1'b1;
            end
          end else if (timeout_hit) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
            o_done    <= 1'b1;
            o_fault   <= 1'b1;
          end
        end
        WAIT1: begin
          if (i_dmem_rvld) begin
            cnt_reg     <= '0;
            rbuf_hi_reg <= i_dmem_rdata;
            state_reg   <= DONE;
            o_done      <= 1'b1;
            o_rdata     <= load_data;
          end else if (timeout_hit) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
            o_done    <= 1'b1;
            o_fault   <= 1'b1;
          end
        end
        DONE: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Beat outputs decode straight from state so they hold steady until granted.
  always_comb begin
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_be    = '0;
    o_dmem_wdata = '0;
    if (state_reg == REQ0) begin
      o_dmem_req   = 1'b1;
      o_dmem_we    = we_reg;
      o_dmem_addr  = word_addr;
      o_dmem_be    = be0;
      o_dmem_wdata = we_reg ? wdata0 : 32'd0;
    end else if (state_reg == REQ1) begin
      o_dmem_req   = 1'b1;
      o_dmem_we    = we_reg;
      o_dmem_addr  = word_addr + 32'd4;
      o_dmem_be    = be1;
      o_dmem_wdata = we_reg ? wdata1 : 32'd0;
    end
  end

  assign o_stall = ((state_reg == IDLE) && i_mem_vld) ||
                   (state_reg == REQ0) || (state_reg == WAIT0) ||
                   (state_reg == REQ1) || (state_reg == WAIT1);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: byte-level memory reference model, a
// handshaking memory responder and directed boundary cases.
module tb_lsu_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_mem_vld = 1'b0;
  logic        i_mem_we = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_wdata = 32'd0;
  logic        o_stall, o_done, o_fault;
  logic [31:0] o_rdata;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_gnt = 1'b0;
  logic        i_dmem_rvld = 1'b0;
  logic [31:0] i_dmem_rdata = 32'd0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_mem_vld(i_mem_vld), .i_mem_we(i_mem_we), .i_funct3(i_funct3),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata), .o_fault(o_fault),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvld(i_dmem_rvld), .i_dmem_rdata(i_dmem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory: init_w written only by the stimulus, mem_w only by the responder.
  logic [31:0] init_w [logic [31:0]];
  logic [31:0] mem_w  [logic [31:0]];
  logic [7:0]  ref_b  [logic [31:0]];

  function automatic logic [31:0] dmem_word(input logic [31:0] wa);
    if (mem_w.exists(wa)) return mem_w[wa];
    if (init_w.exists(wa)) return init_w[wa];
    return 32'd0;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] ba);
    if (ref_b.exists(ba)) return ref_b[ba];
    return 8'd0;
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] d);
    init_w[wa] = d;
    for (int i = 0; i < 4; i++) ref_b[wa + 32'(i)] = d[8*i +: 8];
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  beat_t obs_q[$];
  // gnt_mode: 0 grant at once / rvld next cycle, 1 random delays, 2 never grant, 3 grant but never rvld
  int          gnt_mode = 0;
  int          rv_wait = 0;
  logic [31:0] rv_data = 32'd0;
  int          late_req = 0;
  int          late_done = 0;
  beat_t       rsp_beat;
  logic [31:0] rsp_word;

  always @(negedge clk) begin
    i_dmem_gnt   = 1'b0;
    i_dmem_rvld  = 1'b0;
    i_dmem_rdata = $urandom;
    if (!rst_n) rv_wait = 0;
    if (rv_wait > 0) begin
      rv_wait--;
      if (rv_wait == 0) begin
        i_dmem_rvld  = 1'b1;
        i_dmem_rdata = rv_data;
      end
    end else if (late_done != late_req) begin
      late_done++;
      i_dmem_gnt  = 1'b1;
      i_dmem_rvld = 1'b1;
    end else if (o_dmem_req && gnt_mode != 2 &&
                 (gnt_mode != 1 || $urandom_range(0, 3) != 0)) begin
      i_dmem_gnt     = 1'b1;
      rsp_beat.addr  = o_dmem_addr;
      rsp_beat.be    = o_dmem_be;
      rsp_beat.we    = o_dmem_we;
      rsp_beat.wdata = o_dmem_wdata;
      obs_q.push_back(rsp_beat);
      if (o_dmem_we) begin
        rsp_word = dmem_word(o_dmem_addr);
        for (int i = 0; i < 4; i++)
          if (o_dmem_be[i]) rsp_word[8*i +: 8] = o_dmem_wdata[8*i +: 8];
        mem_w[o_dmem_addr] = rsp_word;
      end else if (gnt_mode != 3) begin
        rv_data = dmem_word(o_dmem_addr);
        rv_wait = (gnt_mode == 1) ? $urandom_range(1, 3) : 1;
      end
    end
  end

  logic [31:0] exp_rdata = 32'd0;

  task automatic do_op(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int mode);
    int n, nb, lat, stall_cnt, req_cnt, obs_base, exp_beats, exp_lat;
    bit done, legal, exp_fault;
    logic [31:0] ba, wa, val, memv;
    logic [31:0] eaddr[2];
    logic [3:0]  ebe[2];
    logic [63:0] wide;
    beat_t ob;

    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb = 0;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      wa = {ba[31:2], 2'b00};
      if (nb == 0 || eaddr[nb-1] != wa) begin
        eaddr[nb] = wa;
        ebe[nb] = 4'd0;
        nb++;
      end
      ebe[nb-1][ba[1:0]] = 1'b1;
    end
    wide = {32'd0, wd} << (8 * a[1:0]);
    exp_fault = !legal || mode == 2 || (mode == 3 && !we);
    exp_beats = (!legal || mode == 2) ? 0 : (mode == 3 && !we) ? 1 : nb;
    if (!exp_fault && !we) begin
      val = 32'd0;
      for (int i = 0; i < n; i++) val |= 32'(ref_byte(a + 32'(i))) << (8 * i);
      if (f3 == 3'b000) val = {{24{val[7]}}, val[7:0]};
      else if (f3 == 3'b001) val = {{16{val[15]}}, val[15:0]};
      exp_rdata = val;
    end
    if (!exp_fault && we)
      for (int i = 0; i < n; i++) ref_b[a + 32'(i)] = wd[8*i +: 8];
    exp_lat = !legal ? 1 : we ? 1 + nb : 1 + 2 * nb;

    obs_base = obs_q.size();
    gnt_mode = mode;
    @(negedge clk);
    i_mem_vld = 1'b1; i_mem_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
    #1;
    stall_cnt = o_stall ? 1 : 0;
    check_eq({name, ".stall_acc"}, {31'd0, o_stall}, 32'd1);
    @(posedge clk);
    #1;
    i_mem_vld = 1'b0; i_mem_we = 1'($urandom); i_funct3 = 3'($urandom);
    i_addr = $urandom; i_wdata = $urandom;
    lat = 0; req_cnt = 0; done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (o_done) done = 1'b1;
      else begin
        if (o_stall) stall_cnt++;
        if (o_dmem_req) req_cnt++;
      end
    end
    check_eq({name, ".done"}, {31'd0, done}, 32'd1);
    check_eq({name, ".fault"}, {31'd0, o_fault}, {31'd0, exp_fault});
    check_eq({name, ".rdata"}, o_rdata, exp_rdata);
    check_eq({name, ".stall_done"}, {31'd0, o_stall}, 32'd0);
    if (mode == 0 || !legal) begin
      check_eq({name, ".latency"}, lat, exp_lat);
      check_eq({name, ".stall_cycles"}, stall_cnt, exp_lat);
    end else if (mode == 2) begin
      check_eq({name, ".to_latency"}, lat, 1 + TIMEOUT);
      check_eq({name, ".to_req_cycles"}, req_cnt, TIMEOUT);
    end else if (mode == 3 && !we) begin
      check_eq({name, ".to_latency"}, lat, 2 + TIMEOUT);
    end
    check_eq({name, ".beats"}, obs_q.size() - obs_base, exp_beats);
    for (int k = 0; k < exp_beats && obs_base + k < obs_q.size(); k++) begin
      ob = obs_q[obs_base + k];
      check_eq({name, ".beat_addr"}, ob.addr, eaddr[k]);
      check_eq({name, ".beat_be"}, {28'd0, ob.be}, {28'd0, ebe[k]});
      check_eq({name, ".beat_we"}, {31'd0, ob.we}, {31'd0, we});
      if (we) check_eq({name, ".beat_wdata"}, ob.wdata, wide[32*k +: 32]);
    end
    if (we && !exp_fault) begin
      for (int k = 0; k < nb; k++) begin
        memv = {ref_byte(eaddr[k] + 32'd3), ref_byte(eaddr[k] + 32'd2),
                ref_byte(eaddr[k] + 32'd1), ref_byte(eaddr[k])};
        check_eq({name, ".mem"}, dmem_word(eaddr[k]), memv);
      end
    end
    $display("TXN %-12s we=%0d f3=%0d addr=%h mode=%0d lat=%0d beats=%0d fault=%0d rdata=%h",
             name, we, f3, a, mode, lat, obs_q.size() - obs_base, o_fault, o_rdata);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, mode;
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

    #2;
    check_eq("reset.stall", {31'd0, o_stall}, 32'd0);
    check_eq("reset.done", {31'd0, o_done}, 32'd0);
    check_eq("reset.fault", {31'd0, o_fault}, 32'd0);
    check_eq("reset.rdata", o_rdata, 32'd0);
    check_eq("reset.req", {31'd0, o_dmem_req}, 32'd0);
    check_eq("reset.addr", o_dmem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    preload(32'h100, 32'hDEADBEEF);
    do_op("lw_aligned", 1'b0, 3'b010, 32'h100, 32'd0, 0);
    check_eq("lw_aligned.const", o_rdata, 32'hDEADBEEF);

    preload(32'h100, 32'h11223344);
    preload(32'h104, 32'hAABBCCDD);
    do_op("lh_split", 1'b0, 3'b001, 32'h103, 32'd0, 0);
    check_eq("lh_split.const", o_rdata, 32'hFFFFDD11);
    do_op("lhu_split", 1'b0, 3'b101, 32'h103, 32'd0, 0);
    check_eq("lhu_split.const", o_rdata, 32'h0000DD11);

    do_op("sw_split", 1'b1, 3'b010, 32'h102, 32'h12345678, 0);

    do_op("lb_no_gnt", 1'b0, 3'b000, 32'h001, 32'd0, 2);
    late_req++;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("late_rvld.rdata", o_rdata, exp_rdata);
    check_eq("late_rvld.stall", {31'd0, o_stall}, 32'd0);
    check_eq("late_rvld.done", {31'd0, o_done}, 32'd0);

    do_op("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'd0, 0);
    do_op("st_f3_100", 1'b1, 3'b100, 32'h100, 32'hFFFFFFFF, 0);

    preload(32'hFFFFFFF8, $urandom);
    preload(32'hFFFFFFFC, 32'h89ABCDEF);
    preload(32'h0, 32'h01234567);
    do_op("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 0);
    do_op("lw_no_rvld", 1'b0, 3'b010, 32'h104, 32'd0, 3);

    // Reset pulled while the load sits waiting for read data
    gnt_mode = 3;
    @(negedge clk);
    i_mem_vld = 1'b1; i_mem_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h300;
    @(posedge clk);
    #1;
    i_mem_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_wait.stall_before", {31'd0, o_stall}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_rdata = 32'd0;
    check_eq("rst_wait.stall", {31'd0, o_stall}, 32'd0);
    check_eq("rst_wait.done", {31'd0, o_done}, 32'd0);
    check_eq("rst_wait.fault", {31'd0, o_fault}, 32'd0);
    check_eq("rst_wait.rdata", o_rdata, 32'd0);
    check_eq("rst_wait.req", {31'd0, o_dmem_req}, 32'd0);
    check_eq("rst_wait.be", {28'd0, o_dmem_be}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    preload(32'h200, 32'h0000CAFE);
    do_op("lw_after_rst", 1'b0, 3'b010, 32'h200, 32'd0, 0);
    check_eq("lw_after_rst.const", o_rdata, 32'h0000CAFE);

    do_op("sh_wrap", 1'b1, 3'b001, 32'hFFFFFFFF, 32'hA5A5BEEF, 0);
    do_op("lhu_wrap", 1'b0, 3'b101, 32'hFFFFFFFF, 32'd0, 0);

    for (int w = 0; w <= 16; w++) preload(32'h1000 + 32'(4 * w), $urandom);
    for (int t = 0; t < 70; t++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else f3 = we ? 3'($urandom_range(0, 2)) : legal_f3[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else a = 32'h1000 + 32'($urandom_range(0, 63));
      r = $urandom_range(0, 19);
      mode = (r == 0) ? 2 : (r == 1) ? 3 : (r < 11) ? 0 : 1;
      do_op($sformatf("rnd%0d", t), we, f3, a, $urandom, mode);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer between the MEM stage (or the single-cycle core's data path) and a handshaked data memory.
- Takes one load/store per request and generates word-aligned memory beats with byte enables.
- Splits word-crossing (misaligned) accesses into two beats, then aligns and sign/zero-extends load data.
- Stalls the pipeline until the access completes; flags illegal funct3 and memory timeouts.

Parameters:
- TIMEOUT, 255: max cycles waiting for i_dmem_gnt or i_dmem_rvld per beat before abort.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_mem_vld  in  1  load/store present in the stage.
- i_mem_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  instruction funct3, i.e. inst[14:12].
- i_addr  in  32  byte address (ALU result).
- i_wdata  in  32  store data (rs2).
- o_stall  out  1  hold the pipeline.
- o_done  out  1  one-cycle completion pulse; the stage advances this cycle.
- o_rdata  out  32  aligned, extended load result.
- o_fault  out  1  valid with o_done: illegal funct3 or timeout.
- o_dmem_req  out  1  memory beat request.
- o_dmem_we  out  1  beat is a write.
- o_dmem_addr  out  32  word address, bits[1:0]=0.
- o_dmem_be  out  4  byte enables, lane i = bits[8i+7:8i].
- o_dmem_wdata  out  32  lane-positioned write data.
- i_dmem_gnt  in  1  beat accepted.
- i_dmem_rvld  in  1  read data valid; earliest the cycle after gnt.
- i_dmem_rdata  in  32  read data.

Behaviour:
- Reset (async, i_reset=0): state IDLE. All outputs 0. Counters and captured fields 0.
- FSM states and transitions:
  - IDLE -> REQ0 on i_mem_vld. IDLE -> DONE on i_mem_vld with illegal funct3 (no memory beat).
  - REQ0 -> WAIT0 on gnt for a load. REQ0 -> REQ1 (split) or DONE on gnt for a store.
  - WAIT0 -> REQ1 (split) or DONE on rvld.
  - REQ1 -> WAIT1 on gnt for a load. REQ1 -> DONE on gnt for a store.
  - WAIT1 -> DONE on rvld.
  - DONE -> IDLE unconditionally.
- Capture: addr, funct3, we and wdata are registered on acceptance in IDLE. Later changes on pipeline inputs are ignored.
- o_stall = (IDLE & i_mem_vld) | state in {REQ0, WAIT0, REQ1, WAIT1}. o_stall is 0 in DONE.
- o_done = 1 only in DONE. A request is never accepted in DONE; the next request is taken in IDLE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All others are illegal: o_fault=1 at DONE, o_rdata unchanged.
- Size n = 1, 2 or 4 bytes; off = addr[1:0]. mask8 = ((1<<n)-1) << off.
  - Beat0: be = mask8[3:0], address = {addr[31:2], 2'b00}.
  - Split when off + n > 4. Beat1: be = mask8[7:4], address = beat0 address + 4. Wraps 0xFFFFFFFC -> 0x00000000.
- Write data: 64-bit value (wdata << 8*off). Low 32 bits go to beat0, high 32 bits to beat1.
- o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be and o_dmem_wdata are driven from state and held stable in REQ0/REQ1 until gnt. All are 0 in other states.
- Load data:
  - Beat0 rdata goes to the low word of a 64-bit buffer; beat1 rdata goes to the high word.
  - Result = buffer >> 8*off, then sign-extended (LB, LH) or zero-extended (LBU, LHU) from n bytes.
  - o_rdata is registered at the DONE transition and held until the next DONE. Stores leave it unchanged.
- Timeout: counter clears on each state entry and increments in REQx/WAITx. When it reaches TIMEOUT: go to DONE, o_fault=1, drop o_dmem_req. Late rvld/gnt in DONE or IDLE is ignored.
- Latency from accept to DONE, with gnt in the request cycle and rvld the next cycle:
  - Aligned load: 3 cycles.
  - Aligned store: 2 cycles.
  - Split load: 5 cycles.
  - Split store: 3 cycles.

Decomposition:
- Package lsu_pkg: funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW), lsu_state_e enum, size-decode function.
- Sub-module lsu_align (combinational): byte-enable generation, write-lane shift and load extract/extend.
- lsu_ctrl holds the FSM, capture registers, read buffer and timeout counter.

Test Plan:
- LW 0x100; gnt immediate, rvld next cycle with 0xDEADBEEF -> one beat (addr 0x100, be 1111); o_rdata=0xDEADBEEF; o_done 3 cycles after accept; o_stall high for exactly those 3 cycles.
- LH 0x103; mem[0x100]=0x11223344, mem[0x104]=0xAABBCCDD -> beats (0x100, be 1000) then (0x104, be 0001); o_rdata=0xFFFFDD11. Repeat as LHU -> 0x0000DD11.
- SW 0x12345678 at 0x102 -> beat0 (0x100, be 1100, wdata 0x56780000); beat1 (0x104, be 0011, wdata 0x00001234); o_fault=0.
- LB 0x001 with gnt withheld -> o_dmem_req held TIMEOUT cycles then dropped; DONE with o_fault=1; a late rvld is ignored.
- Reset pulled low during WAIT0 of an LW -> all outputs 0 immediately. After release, LW 0x200 (data 0x0000CAFE) completes normally.
- Load with funct3=011 -> no o_dmem_req; o_done next cycle with o_fault=1; o_rdata keeps its prior value.
